// File: rtl/avalon_pkg.sv
// rtl/avalon_pkg.sv - shared state type and width helper for the Avalon-ST packetizer
package avalon_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_MSG = 1'b1
    } state_t;

    // Width of the empty field for a W-byte word; never narrower than one bit.
    function automatic int empty_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// rtl/avalon_st_if.sv - Avalon-ST style stream bundle with source/sink modports
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EW = avalon_pkg::empty_width(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [EW-1:0]                    empty;
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;

    modport master (output valid, sop, eop, empty, data, input rdy);
    modport slave  (input valid, sop, eop, empty, data, output rdy);
endinterface

// File: rtl/avalon_empty_masker.sv
// rtl/avalon_empty_masker.sv - zeroes the lowest 'empty' bytes of a word when enabled
module avalon_empty_masker
    import avalon_pkg::*;
#(
    parameter int W  = 16,
    parameter int EW = empty_width(W)
) (
    input  logic [W*8-1:0] data,
    input  logic [EW-1:0]  empty,
    input  logic           enable,
    output logic [W*8-1:0] masked
);

    always_comb begin
        masked = data;
        if (enable) begin
            for (int i = 0; i < W; i++) begin
                if (EW'(i) < empty) masked[i*8 +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/avalon_packetizer.sv
// rtl/avalon_packetizer.sv - frames raw words into sop/eop/empty messages; AVALON_PACKETIZER_ZERO_PAD_EN zeroes pad bytes
module avalon_packetizer
    import avalon_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 len_valid,
    output logic                 len_rdy,
    input  logic [LEN_WIDTH-1:0] len,
    avalon_st_if.slave           raw_data,
    avalon_st_if.master          framed_msg,
    output logic                 msg_done_indi,
    output logic                 zero_len_indi
);

    localparam int W  = DATA_WIDTH_IN_BYTES;
    localparam int EW = empty_width(W);

    state_t               state, state_n;
    logic [LEN_WIDTH-1:0] word_cnt, words_total;
    logic [EW-1:0]        last_empty;
    logic [LEN_WIDTH-1:0] words_total_n;
    logic [EW-1:0]        last_empty_n;
    logic                 accept, zero_cmd, beat;
    logic                 valid_o, sop_o, eop_o, pad_en;
    logic [EW-1:0]        empty_o;
    logic [W*8-1:0]       data_o;

    // Ceiling divide by a power of two: shift, then round up on any remainder.
    assign words_total_n = (len >> EW) + {{(LEN_WIDTH-1){1'b0}}, |len[EW-1:0]};
    assign last_empty_n  = ~len[EW-1:0] + EW'(1);

    always_comb begin
        state_n  = state;
        len_rdy  = 1'b0;
        accept   = 1'b0;
        zero_cmd = 1'b0;
        valid_o  = 1'b0;
        sop_o    = 1'b0;
        eop_o    = 1'b0;
        empty_o  = '0;
        beat     = 1'b0;
        case (state)
            IDLE: begin
                len_rdy  = 1'b1;
                accept   = len_valid && (len != '0);
                zero_cmd = len_valid && (len == '0);
                if (accept) state_n = IN_MSG;
            end
            IN_MSG: begin
                valid_o = raw_data.valid;
                sop_o   = valid_o && (word_cnt == '0);
                eop_o   = valid_o && (word_cnt == words_total - LEN_WIDTH'(1));
                empty_o = eop_o ? last_empty : '0;
                beat    = valid_o && framed_msg.rdy;
                if (beat && eop_o) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef AVALON_PACKETIZER_ZERO_PAD_EN
    assign pad_en = eop_o;
`else
    assign pad_en = 1'b0;
`endif

    avalon_empty_masker #(.W(W), .EW(EW)) u_masker (
        .data   (raw_data.data),
        .empty  (empty_o),
        .enable (pad_en),
        .masked (data_o)
    );

    assign raw_data.rdy     = (state == IN_MSG) && framed_msg.rdy;
    assign framed_msg.valid = valid_o;
    assign framed_msg.sop   = sop_o;
    assign framed_msg.eop   = eop_o;
    assign framed_msg.empty = empty_o;
    assign framed_msg.data  = data_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            word_cnt      <= '0;
            words_total   <= '0;
            last_empty    <= '0;
            msg_done_indi <= 1'b0;
            zero_len_indi <= 1'b0;
        end else begin
            state         <= state_n;
            msg_done_indi <= beat && eop_o;
            zero_len_indi <= zero_cmd;
            if (accept) begin
                word_cnt    <= '0;
                words_total <= words_total_n;
                last_empty  <= last_empty_n;
            end else if (beat) begin
                word_cnt <= word_cnt + LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_avalon_packetizer.sv
// tb/tb_avalon_packetizer.sv - randomized self-checking bench against a message-level reference model
module tb_avalon_packetizer;

    localparam int W  = 16;
    localparam int LW = 16;
    localparam int DW = W * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          len_valid = 1'b0;
    logic          len_rdy;
    logic [LW-1:0] len = '0;
    logic          msg_done_indi;
    logic          zero_len_indi;

    int checks = 0;
    int errors = 0;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) raw_data ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) framed_msg ();

    avalon_packetizer #(.DATA_WIDTH_IN_BYTES(W), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .len_valid     (len_valid),
        .len_rdy       (len_rdy),
        .len           (len),
        .raw_data      (raw_data),
        .framed_msg    (framed_msg),
        .msg_done_indi (msg_done_indi),
        .zero_len_indi (zero_len_indi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference: padding bytes are the lowest 'empty' byte lanes of the last word.
    function automatic logic [DW-1:0] model_data(input logic [DW-1:0] d, input int empty, input bit last);
        logic [DW-1:0] r;
        r = d;
`ifdef AVALON_PACKETIZER_ZERO_PAD_EN
        if (last) for (int b = 0; b < empty; b++) r[b*8 +: 8] = 8'h00;
`endif
        return r;
    endfunction

    // mode 0: no backpressure; 1: random valid/rdy; 2: rdy low 3 cycles during beat 2
    task automatic run_msg(input int l, input int mode, input bit fill_ff);
        int            words, exp_empty, k, cyc, stall;
        bit            v, r, held;
        logic [DW-1:0] d, prev_data;
        words     = (l + W - 1) / W;
        exp_empty = (W - (l % W)) % W;
        @(negedge clk);
        len_valid = 1'b1;
        len       = l[LW-1:0];
        #1 check("len_rdy_idle", DW'(len_rdy), DW'(1));
        @(negedge clk);
        len_valid = 1'b0;
        if (l == 0) begin
            raw_data.valid = 1'b1;
            #1;
            check("zero_len_pulse", DW'(zero_len_indi), DW'(1));
            check("zero_len_no_valid", DW'(framed_msg.valid), DW'(0));
            check("zero_len_len_rdy", DW'(len_rdy), DW'(1));
            @(negedge clk);
            check("zero_len_once", DW'(zero_len_indi), DW'(0));
            raw_data.valid = 1'b0;
            return;
        end
        k = 0; cyc = 0; stall = 0; held = 1'b0; d = '0; prev_data = '0;
        while (k < words && cyc < 20000) begin
            if (!held) d = fill_ff ? '1 : {$urandom, $urandom, $urandom, $urandom};
            case (mode)
                0:       begin v = 1'b1; r = 1'b1; end
                1:       begin v = held || ($urandom_range(3) != 0); r = ($urandom_range(2) != 0); end
                default: begin
                    v = 1'b1;
                    r = !(k == 1 && stall < 3);
                    if (!r) stall++;
                end
            endcase
            raw_data.valid  = v;
            raw_data.data   = d;
            framed_msg.rdy  = r;
            #1;
            check("valid_pass", DW'(framed_msg.valid), DW'(v));
            check("rdy_pass", DW'(raw_data.rdy), DW'(r));
            check("len_rdy_busy", DW'(len_rdy), DW'(0));
            check("done_quiet", DW'(msg_done_indi), DW'(0));
            if (v) begin
                check("sop", DW'(framed_msg.sop), DW'(k == 0));
                check("eop", DW'(framed_msg.eop), DW'(k == words - 1));
                check("empty", DW'(framed_msg.empty), DW'((k == words - 1) ? exp_empty : 0));
                check("data", framed_msg.data, model_data(d, exp_empty, k == words - 1));
                if (held) check("stall_stable", framed_msg.data, prev_data);
                prev_data = framed_msg.data;
            end
            held = v && !r;
            if (v && r) k++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20000) check("msg_timeout", DW'(k), DW'(words));
        raw_data.valid = 1'b1;
        framed_msg.rdy = 1'b1;
        #1;
        check("done_pulse", DW'(msg_done_indi), DW'(1));
        check("idle_len_rdy", DW'(len_rdy), DW'(1));
        check("idle_no_valid", DW'(framed_msg.valid), DW'(0));
        @(negedge clk);
        check("done_once", DW'(msg_done_indi), DW'(0));
        raw_data.valid = 1'b0;
    endtask

    initial begin
        int l;
        raw_data.valid = 1'b1;
        raw_data.sop   = 1'b0;
        raw_data.eop   = 1'b0;
        raw_data.empty = '0;
        raw_data.data  = '0;
        framed_msg.rdy = 1'b1;
        #12;
        check("rst_len_rdy", DW'(len_rdy), DW'(1));
        check("rst_valid", DW'(framed_msg.valid), DW'(0));
        check("rst_done", DW'(msg_done_indi), DW'(0));
        check("rst_zero", DW'(zero_len_indi), DW'(0));
        @(negedge clk);
        rst = 1'b1;
        raw_data.valid = 1'b0;

        run_msg(48, 0, 1'b0);
        run_msg(17, 0, 1'b1);
        run_msg(1, 0, 1'b0);
        run_msg(48, 2, 1'b0);
        run_msg(0, 0, 1'b0);
        run_msg(16, 1, 1'b1);

        // Reset mid-message: abandon after the first beat.
        @(negedge clk);
        len_valid = 1'b1;
        len       = LW'(48);
        @(negedge clk);
        len_valid      = 1'b0;
        raw_data.valid = 1'b1;
        raw_data.data  = '1;
        framed_msg.rdy = 1'b1;
        #1 check("rst_mid_sop", DW'(framed_msg.sop), DW'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_valid", DW'(framed_msg.valid), DW'(0));
        check("rst_mid_eop", DW'(framed_msg.eop), DW'(0));
        check("rst_mid_len_rdy", DW'(len_rdy), DW'(1));
        @(negedge clk);
        rst = 1'b1;
        raw_data.valid = 1'b0;
        #1 check("rst_mid_no_done", DW'(msg_done_indi), DW'(0));
        run_msg(32, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(5))
                0:       l = 0;
                1:       l = W * $urandom_range(1, 6);
                2:       l = W * $urandom_range(1, 6) + 1;
                default: l = $urandom_range(1, 200);
            endcase
            run_msg(l, $urandom_range(2), $urandom_range(1) == 1);
        end
        run_msg((1 << LW) - 1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_packetizer.md
AVALON_PACKETIZER -- requirements
Module: avalon_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_IN_BYTES, default 16, meaning bytes per data word (W); legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, meaning the width of the byte-length command.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 len_valid  input  1  a message-length command is offered.
REQ-006 len_rdy  output  1  the block accepts a length command this cycle.
REQ-007 len  input  LEN_WIDTH  message length in bytes.
REQ-008 raw_data  avalon_st_if.slave  W*8 data  unframed payload words; only valid/data/rdy are used, sop/eop/empty are ignored.
REQ-009 framed_msg  avalon_st_if.master  W*8 data  framed Avalon-ST output carrying valid/rdy/sop/eop/empty/data.
REQ-010 msg_done_indi  output  1  one-cycle pulse after each message completes.
REQ-011 zero_len_indi  output  1  one-cycle pulse when a zero-length command is dropped.

Function
REQ-012 SHALL implement two states: IDLE and IN_MSG.
REQ-013 IDLE: len_rdy=1, raw_data.rdy=0, framed_msg.valid=0.
REQ-014 IDLE, len_valid=1, len!=0: SHALL latch words_total=ceil(len/W) and last_empty=(W - len mod W) mod W, clear word_cnt to 0, and go to IN_MSG next cycle.
REQ-015 IDLE, len_valid=1, len==0: SHALL accept and discard the command, stay in IDLE, and pulse zero_len_indi the next cycle.
REQ-016 IN_MSG: len_rdy=0, raw_data.rdy=framed_msg.rdy (combinational), framed_msg.valid=raw_data.valid, framed_msg.data=raw_data.data, with zero added latency.
REQ-017 framed_msg.sop SHALL be 1 only when valid and word_cnt==0.
REQ-018 framed_msg.eop SHALL be 1 only when valid and word_cnt==words_total-1.
REQ-019 framed_msg.empty SHALL equal last_empty when eop=1 and SHALL be 0 otherwise.
REQ-020 A single-word message (words_total==1) SHALL assert sop and eop on the same beat.
REQ-021 word_cnt SHALL increment only on a beat, defined as framed_msg.valid & framed_msg.rdy.
REQ-022 On a beat with eop=1: SHALL go to IDLE next cycle and pulse msg_done_indi for exactly one cycle on that next cycle.
REQ-023 sop, eop, empty and data SHALL stay stable while valid=1 and rdy=0.
REQ-024 A new command SHALL NOT be accepted in the cycle of the eop beat; the minimum gap between messages is one IDLE cycle.
REQ-025 word_cnt and words_total SHALL be LEN_WIDTH bits wide; empty SHALL be $clog2(W) bits wide; len=2^LEN_WIDTH-1 SHALL be handled without overflow.

Reset
REQ-026 While rst=0: state=IDLE; word_cnt, words_total and last_empty are 0; msg_done_indi=0, zero_len_indi=0, framed_msg.valid=0, len_rdy=1.
REQ-027 Reset asserted mid-message SHALL abandon the message with no eop emitted; after release the block waits in IDLE for a new command.

Configuration
REQ-028 Macro AVALON_PACKETIZER_ZERO_PAD_EN defined: on an eop beat, data bytes [empty-1:0] (lowest byte indices) SHALL be driven to 0.
REQ-029 Macro AVALON_PACKETIZER_ZERO_PAD_EN undefined: data SHALL pass through unmodified on every beat.

Structure
REQ-030 A shared package avalon_pkg SHALL hold the state enum type (IDLE, IN_MSG) and the function that computes empty width from W.
REQ-031 The zero-pad byte mask SHALL be a sub-module avalon_empty_masker (data, empty, enable -> masked data), instantiated once.

Verification
REQ-032 W=16, len=48, no backpressure -> 3 beats: sop on beat 1, eop on beat 3, empty=0; msg_done_indi pulses one cycle later.
REQ-033 W=16, len=17, macro defined, data all 0xFF -> 2 beats; on beat 2 eop=1, empty=15, bytes [14:0]=0x00, byte 15=0xFF.
REQ-034 W=16, len=1 -> single beat with sop=1, eop=1, empty=15.
REQ-035 W=16, len=48, framed_msg.rdy low for 3 cycles during beat 2 -> outputs held stable, word_cnt unchanged, 3 beats total.
REQ-036 len=0 -> zero_len_indi pulses once, no framed_msg.valid, len_rdy stays 1.
REQ-037 rst asserted after beat 1 of a 3-beat message -> IDLE immediately, valid=0; the next len=32 command produces a clean 2-beat message beginning with sop.
